// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the instruction/data RAM port arbiter.
// Holds the FSM and owner encodings, the latched-request bundle and the watchdog width helper.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef struct packed {
    owner_t      own;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  localparam logic [31:0] UART_ADDR_DEF = 32'h1000_0000;
  localparam int          TIMEOUT_DEF   = 16;

  function automatic int wd_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port not served last wins.
// req[0]/gnt[0] is the fetch port, req[1]/gnt[1] the load/store port; last=1 means D.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-ported multi-cycle data RAM between fetch and load/store.
// One access at a time through cs/we/ack, round-robin on ties, watchdog abort.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int          TIMEOUT   = TIMEOUT_DEF,
  parameter logic [31:0] UART_ADDR = UART_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        d_stall,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic        ram_ack,
  output logic [1:0]  owner
);

  localparam int WD_W = wd_width(TIMEOUT);

  state_t          state_q, state_d;
  acc_t            cur_q, cur_d;
  logic            last_q, last_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [1:0]      gnt;
  logic            busy, done;

  // The UART is just another address to the arbiter.
  logic unused_uart;
  assign unused_uart = ^UART_ADDR;

  rr_pick2 u_pick (
    .req  ({d_req, i_req}),
    .last (last_q),
    .gnt  (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= 1'b0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          cur_d.own   = gnt[1] ? OWN_D : OWN_I;
          cur_d.addr  = gnt[1] ? d_addr : i_addr;
          cur_d.we    = gnt[1] & d_we;
          cur_d.wdata = gnt[1] ? d_wdata : '0;
          wd_d        = '0;
          err_d       = 1'b0;
          rdata_d     = '0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        wd_d = wd_q + 1'b1;
        if (ram_ack) begin
          rdata_d = cur_q.we ? '0 : ram_dout;
          last_d  = (cur_q.own == OWN_D);
          state_d = ST_DONE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cur_d.own = OWN_NONE;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_BUSY);
  assign done = (state_q == ST_DONE);

  // Bus is fully quiet outside BUSY so a stale address cannot trigger a device.
  assign ram_cs   = busy & ~ram_ack;
  assign ram_we   = busy & cur_q.we;
  assign ram_addr = busy ? cur_q.addr : '0;
  assign ram_din  = busy ? cur_q.wdata : '0;

  assign i_ack   = done & (cur_q.own == OWN_I);
  assign d_ack   = done & (cur_q.own == OWN_D);
  assign i_err   = i_ack & err_q;
  assign d_err   = d_ack & err_q;
  assign i_rdata = i_ack ? rdata_q : '0;
  assign d_rdata = d_ack ? rdata_q : '0;
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;
  assign owner   = cur_q.own;

endmodule
